operand_fetch_stage: RTL

//  Decode-to-execute pipeline stage. Accepts decoded instructions (rs1/rs2/rd + payload) over valid/ready.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/reg_scoreboard.sv | 64 ++++++
 rtl/operand_fetch_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Core-wide constants and types shared by decode, register_file
//               and operand_fetch_stage.
//               XLEN       - integer register / datapath width
//               REG_ADDR_W - register index width
//               NUM_REGS   - architectural integer register count
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register "write pending" bits. A bit is set when an
//               instruction that writes that register leaves this stage, and
//               cleared when the register file write for it is seen.
// Ports       : clk, rst (async, active-low)
//               set_en/set_addr     - mark a register pending
//               clr_en/clr_addr     - writeback observed for a register
//               query_addr_0..2     - indices to look up
//               query_pend_0..2     - current pending bit of each index
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import riscv_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_addr,
    input  logic      clr_en,
    input  reg_addr_t clr_addr,
    input  reg_addr_t query_addr_0,
    input  reg_addr_t query_addr_1,
    input  reg_addr_t query_addr_2,
    output logic      query_pend_0,
    output logic      query_pend_1,
    output logic      query_pend_2
);

    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_pend_next;

    // Set is applied after clear so that a new writer issued in the same cycle
    // its predecessor writes back keeps the register pending.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (set_en) begin
            w_set_mask[set_addr] = 1'b1;
        end
        if (clr_en) begin
            w_clr_mask[clr_addr] = 1'b1;
        end
        w_pend_next    = (r_pend & ~w_clr_mask) | w_set_mask;
        w_pend_next[0] = 1'b0;  // x0 is never written, never pending
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign query_pend_0 = r_pend[query_addr_0];
    assign query_pend_1 = r_pend[query_addr_1];
    assign query_pend_2 = r_pend[query_addr_2];

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Decode-to-execute stage. Reads both source operands from the
//               register file, bypasses a same-cycle writeback, stalls on
//               RAW/WAW hazards tracked by a pending scoreboard and presents a
//               registered operand bundle to execute over valid/ready.
// Ports       : clk, rst (async, active-low), flush
//               in_valid/in_ready, in_rs1, in_rs2, in_rd, in_payload  - decode
//               rf_read_address_0/1, rf_read_data_0/1                 - regfile
//               wb_write_enable/address/data                          - snooped
//               out_valid/out_ready, out_rs1_value, out_rs2_value,
//               out_rd, out_payload                                   - execute
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = riscv_pkg::XLEN,
    parameter int PAYLOAD_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  reg_addr_t            in_rs1,
    input  reg_addr_t            in_rs2,
    input  reg_addr_t            in_rd,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output reg_addr_t            rf_read_address_0,
    output reg_addr_t            rf_read_address_1,
    input  logic [XLEN-1:0]      rf_read_data_0,
    input  logic [XLEN-1:0]      rf_read_data_1,
    input  logic                 wb_write_enable,
    input  reg_addr_t            wb_write_address,
    input  logic [XLEN-1:0]      wb_write_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_rs1_value,
    output logic [XLEN-1:0]      out_rs2_value,
    output reg_addr_t            out_rd,
    output logic [PAYLOAD_W-1:0] out_payload
);

    localparam reg_addr_t c_x0 = '0;

    logic                 r_out_valid;
    logic [XLEN-1:0]      r_out_rs1_value;
    logic [XLEN-1:0]      r_out_rs2_value;
    reg_addr_t            r_out_rd;
    logic [PAYLOAD_W-1:0] r_out_payload;

    logic w_pend_rs1;
    logic w_pend_rs2;
    logic w_pend_rd;
    logic w_wb_hit_rs1;
    logic w_wb_hit_rs2;
    logic w_busy_rs1;
    logic w_busy_rs2;
    logic w_busy_rd;
    logic w_hazard;
    logic w_accept;
    logic w_out_hs;
    logic [XLEN-1:0] w_rs1_value;
    logic [XLEN-1:0] w_rs2_value;

    assign rf_read_address_0 = in_rs1;
    assign rf_read_address_1 = in_rs2;

    assign w_out_hs = r_out_valid && out_ready;

    reg_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .set_en       (w_out_hs && (r_out_rd != c_x0)),
        .set_addr     (r_out_rd),
        .clr_en       (wb_write_enable && (wb_write_address != c_x0)),
        .clr_addr     (wb_write_address),
        .query_addr_0 (in_rs1),
        .query_addr_1 (in_rs2),
        .query_addr_2 (in_rd),
        .query_pend_0 (w_pend_rs1),
        .query_pend_1 (w_pend_rs2),
        .query_pend_2 (w_pend_rd)
    );

    // Writeback bypass: the register file only shows the new value next cycle.
    assign w_wb_hit_rs1 = wb_write_enable && (wb_write_address == in_rs1) && (in_rs1 != c_x0);
    assign w_wb_hit_rs2 = wb_write_enable && (wb_write_address == in_rs2) && (in_rs2 != c_x0);
    assign w_rs1_value  = w_wb_hit_rs1 ? wb_write_data : rf_read_data_0;
    assign w_rs2_value  = w_wb_hit_rs2 ? wb_write_data : rf_read_data_1;

    // A source is busy if its writer has left this stage and not yet written
    // back (unless that writeback is happening now), or if its writer is still
    // sitting in the output register (no forwarding from execute).
    assign w_busy_rs1 = (in_rs1 != c_x0) &&
                        ((w_pend_rs1 && !w_wb_hit_rs1) || (r_out_valid && (r_out_rd == in_rs1)));
    assign w_busy_rs2 = (in_rs2 != c_x0) &&
                        ((w_pend_rs2 && !w_wb_hit_rs2) || (r_out_valid && (r_out_rd == in_rs2)));
    // WAW: one outstanding writer per register; a clearing writeback does not
    // release the destination in the same cycle.
    assign w_busy_rd  = (in_rd != c_x0) &&
                        (w_pend_rd || (r_out_valid && (r_out_rd == in_rd)));

    assign w_hazard = w_busy_rs1 || w_busy_rs2 || w_busy_rd;
    assign in_ready = rst && !flush && !w_hazard && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid     <= 1'b0;
            r_out_rs1_value <= '0;
            r_out_rs2_value <= '0;
            r_out_rd        <= '0;
            r_out_payload   <= '0;
        end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_out_rs1_value <= w_rs1_value;
            r_out_rs2_value <= w_rs2_value;
            r_out_rd        <= in_rd;
            r_out_payload   <= in_payload;
        end else if (flush || w_out_hs) begin
            r_out_valid     <= 1'b0;
        end
    end

    assign out_valid     = r_out_valid;
    assign out_rs1_value = r_out_rs1_value;
    assign out_rs2_value = r_out_rs2_value;
    assign out_rd        = r_out_rd;
    assign out_payload   = r_out_payload;

endmodule
`default_nettype wire
